// File: rtl/seven_seg_scan_ctrl_if.sv
// Bundle of display-control inputs and scan outputs shared by the
// scan controller (slave) and whoever drives it (master).
interface seven_seg_scan_ctrl_if #(
    parameter int DIGITS = 4
) ();
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  enable;
    logic [DIGITS-1:0]     digit_mask;
    logic [4*DIGITS-1:0]   values;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     anode;
    logic [6:0]            seg;
    logic                  dp_out;
    logic [IW-1:0]         digit_idx;
    logic                  frame_tick;

    modport master (
        output enable, digit_mask, values, dp,
        input  anode, seg, dp_out, digit_idx, frame_tick
    );

    modport slave (
        input  enable, digit_mask, values, dp,
        output anode, seg, dp_out, digit_idx, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: rotates through unmasked digits,
// holding each for DWELL cycles, and drives anode/segment/dp lines.
module seven_seg_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    seven_seg_scan_ctrl_if.slave  bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    logic [IW-1:0] next_idx;
    logic [IW-1:0] cand;
    logic          found;
    logic          advance;

    logic [3:0]        cur_nibble;
    logic              cur_masked;
    logic              cur_dp;
    logic              active;
    logic [DIGITS-1:0] anode_ah;
    logic [6:0]        seg_ah;
    logic              dp_ah;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    // Circular upward search starting after idx; the last candidate is idx itself.
    always_comb begin
        next_idx = idx_q;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= DIGITS; k++) begin
            cand = IW'((int'(idx_q) + k) % DIGITS);
            if (!found && !bus.digit_mask[cand]) begin
                next_idx = cand;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tick_d  = 1'b0;
        advance = 1'b0;
        if (bus.enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                advance = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A fully masked display never moves, so it never reports a frame wrap.
        if (advance && found) begin
            idx_d  = next_idx;
            tick_d = (next_idx <= idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    // Display outputs follow the live inputs so mask/value edits show up at once.
    always_comb begin
        cur_nibble = '0;
        cur_masked = 1'b1;
        cur_dp     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                cur_nibble = bus.values[4*i +: 4];
                cur_masked = bus.digit_mask[i];
                cur_dp     = bus.dp[i];
            end
        end
        active   = bus.enable && !cur_masked;
        anode_ah = '0;
        seg_ah   = '0;
        dp_ah    = 1'b0;
        if (active) begin
            anode_ah[idx_q] = 1'b1;
            seg_ah          = hex_to_seg(cur_nibble);
            dp_ah           = cur_dp;
        end
    end

    assign bus.anode      = ACTIVE_LOW ? ~anode_ah : anode_ah;
    assign bus.seg        = ACTIVE_LOW ? ~seg_ah   : seg_ah;
    assign bus.dp_out     = ACTIVE_LOW ? ~dp_ah    : dp_ah;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_tick = tick_q && bus.enable;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed scan sequence for a 4-digit, 2-cycle-dwell, active-low display;
// expected outputs go through a scoreboard queue and are checked each cycle.
module tb_seven_seg_scan_ctrl;
    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S5 = 7'h12;
    localparam logic [6:0] SA = 7'h08;
    localparam logic [6:0] S8 = 7'h00;
    localparam logic [6:0] SB = 7'h7F;

    typedef struct {
        string      tag;
        logic [3:0] anode;
        logic [1:0] idx;
        logic       tick;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    seven_seg_scan_ctrl_if #(.DIGITS(4)) bus ();

    seven_seg_scan_ctrl #(
        .DIGITS(4),
        .DWELL(2),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input string tag, input logic en, input logic rst,
                                 input logic [3:0] mask, input logic [3:0] e_anode,
                                 input logic [1:0] e_idx, input logic e_tick,
                                 input logic [6:0] e_seg, input logic e_dp);
        exp_t e;
        @(posedge clk);
        #1;
        bus.enable     = en;
        reset          = rst;
        bus.digit_mask = mask;
        e.tag   = tag;
        e.anode = e_anode;
        e.idx   = e_idx;
        e.tick  = e_tick;
        e.seg   = e_seg;
        e.dp    = e_dp;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        #1;
        e = sb_q.pop_front();
        vectors++;
        assert (bus.anode === e.anode) else begin
            miscompares++;
            $error("[TB] FAIL %s anode: got %b expected %b", e.tag, bus.anode, e.anode);
        end
        vectors++;
        assert (bus.digit_idx === e.idx) else begin
            miscompares++;
            $error("[TB] FAIL %s digit_idx: got %0d expected %0d", e.tag, bus.digit_idx, e.idx);
        end
        vectors++;
        assert (bus.frame_tick === e.tick) else begin
            miscompares++;
            $error("[TB] FAIL %s frame_tick: got %b expected %b", e.tag, bus.frame_tick, e.tick);
        end
        vectors++;
        assert (bus.seg === e.seg) else begin
            miscompares++;
            $error("[TB] FAIL %s seg: got %h expected %h", e.tag, bus.seg, e.seg);
        end
        vectors++;
        assert (bus.dp_out === e.dp) else begin
            miscompares++;
            $error("[TB] FAIL %s dp_out: got %b expected %b", e.tag, bus.dp_out, e.dp);
        end
    endtask

    task automatic step(input string tag, input logic en, input logic rst,
                        input logic [3:0] mask, input logic [3:0] e_anode,
                        input logic [1:0] e_idx, input logic e_tick,
                        input logic [6:0] e_seg, input logic e_dp);
        applyStimulus(tag, en, rst, mask, e_anode, e_idx, e_tick, e_seg, e_dp);
        checkOutput();
    endtask

    initial begin
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.digit_mask = 4'b0000;
        bus.values     = 16'h8A50;
        bus.dp         = 4'b0100;
        repeat (2) @(posedge clk);

        step("reset_idle", 0, 0, 4'b0000, 4'b1111, 0, 0, SB, 1);
        step("idle_hold",  0, 0, 4'b0000, 4'b1111, 0, 0, SB, 1);

        step("scan_d0a", 1, 0, 4'b0000, 4'b1110, 0, 0, S0, 1);
        step("scan_d0b", 1, 0, 4'b0000, 4'b1110, 0, 0, S0, 1);
        step("scan_d1a", 1, 0, 4'b0000, 4'b1101, 1, 0, S5, 1);
        step("scan_d1b", 1, 0, 4'b0000, 4'b1101, 1, 0, S5, 1);
        step("scan_d2a", 1, 0, 4'b0000, 4'b1011, 2, 0, SA, 0);
        step("scan_d2b", 1, 0, 4'b0000, 4'b1011, 2, 0, SA, 0);
        step("scan_d3a", 1, 0, 4'b0000, 4'b0111, 3, 0, S8, 1);
        step("scan_d3b", 1, 0, 4'b0000, 4'b0111, 3, 0, S8, 1);
        step("wrap_d0a", 1, 0, 4'b0000, 4'b1110, 0, 1, S0, 1);
        step("wrap_d0b", 1, 0, 4'b0000, 4'b1110, 0, 0, S0, 1);

        step("m0101_d1a", 1, 0, 4'b0101, 4'b1101, 1, 0, S5, 1);
        step("m0101_d1b", 1, 0, 4'b0101, 4'b1101, 1, 0, S5, 1);
        step("m0101_d3a", 1, 0, 4'b0101, 4'b0111, 3, 0, S8, 1);
        step("m0101_d3b", 1, 0, 4'b0101, 4'b0111, 3, 0, S8, 1);
        step("m0101_wrap", 1, 0, 4'b0101, 4'b1101, 1, 1, S5, 1);
        step("m0101_d1c", 1, 0, 4'b0101, 4'b1101, 1, 0, S5, 1);

        for (int i = 0; i < 6; i++)
            step("allmask", 1, 0, 4'b1111, 4'b1111, 3, 0, SB, 1);

        step("unmask_d3a", 1, 0, 4'b0000, 4'b0111, 3, 0, S8, 1);
        step("unmask_d3b", 1, 0, 4'b0000, 4'b0111, 3, 0, S8, 1);
        step("unmask_wrap", 1, 0, 4'b0000, 4'b1110, 0, 1, S0, 1);
        step("unmask_d0b", 1, 0, 4'b0000, 4'b1110, 0, 0, S0, 1);
        step("pre_pause", 1, 0, 4'b0000, 4'b1101, 1, 0, S5, 1);

        for (int i = 0; i < 5; i++)
            step("paused", 0, 0, 4'b0000, 4'b1111, 1, 0, SB, 1);

        step("resume_d1", 1, 0, 4'b0000, 4'b1101, 1, 0, S5, 1);
        step("resume_d2a", 1, 0, 4'b0000, 4'b1011, 2, 0, SA, 0);
        step("resume_d2b", 1, 0, 4'b0000, 4'b1011, 2, 0, SA, 0);
        step("pre_rst_d3a", 1, 0, 4'b0000, 4'b0111, 3, 0, S8, 1);
        step("rst_at_d3b", 1, 1, 4'b0000, 4'b0111, 3, 0, S8, 1);
        step("post_rst_a", 1, 0, 4'b0000, 4'b1110, 0, 0, S0, 1);
        step("post_rst_b", 1, 0, 4'b0000, 4'b1110, 0, 0, S0, 1);
        step("post_rst_d1", 1, 0, 4'b0000, 4'b1101, 1, 0, S5, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of digits scanned; legal range 2..8.
REQ-002 Parameter DWELL, default 4, clk cycles each digit stays lit; legal range 1..65535.
REQ-003 Parameter ACTIVE_LOW, default 1; 1 = anode, seg and dp_out active-low, 0 = active-high.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  1 = scan and drive display; 0 = freeze scan, blank outputs.
REQ-007 digit_mask  input  DIGITS  bit i = 1 blanks digit i and removes it from the rotation.
REQ-008 values  input  4*DIGITS  hex nibble per digit; digit i = values[4i+3:4i].
REQ-009 dp  input  DIGITS  decimal-point request per digit.
REQ-010 anode  output  DIGITS  digit enables, at most one active.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a} for the current digit.
REQ-012 dp_out  output  1  decimal point for the current digit.
REQ-013 digit_idx  output  clog2(DIGITS)  index of the current digit.
REQ-014 frame_tick  output  1  one-cycle pulse on each rotation wrap.

Function
REQ-015 State SHALL be a registered index idx (0..DIGITS-1) and a dwell counter cnt (0..DWELL-1).
REQ-016 When enable=1, cnt SHALL increment each cycle; at cnt=DWELL-1 it SHALL return to 0 and an advance SHALL occur.
REQ-017 On advance, idx SHALL take the next index after idx, searching circularly upward, whose digit_mask bit is 0; idx itself qualifies only if no other digit is unmasked.
REQ-018 If every digit_mask bit is 1, advance SHALL leave idx unchanged and frame_tick SHALL stay 0.
REQ-019 frame_tick SHALL be 1 in exactly the cycle in which an advance is registered with new idx <= old idx, and 0 otherwise.
REQ-020 When enable=0, idx and cnt SHALL hold, frame_tick SHALL be 0 and all outputs SHALL be inactive; on re-enable the remaining dwell SHALL complete without restart.
REQ-021 digit i SHALL be active iff enable=1, idx=i and digit_mask[i]=0; anode, seg and dp_out SHALL be combinational from registered idx and the current inputs, with no added cycle of latency.
REQ-022 seg SHALL decode the current nibble as standard hex 0-F (b and d lowercase); for example, active-high 0=7'h3F, 8=7'h7F, A=7'h77, F=7'h71; ACTIVE_LOW inverts all bits.
REQ-023 When no digit is active, seg and dp_out SHALL be inactive (all 1 when ACTIVE_LOW=1).
REQ-024 digit_mask and values changes SHALL take effect in the same cycle; a mask set on the current digit blanks it immediately and does not shorten its dwell.
REQ-025 DWELL=1 SHALL advance every enabled cycle.

Reset
REQ-026 A reset asserted in any cycle SHALL, at the next edge, set idx=0, cnt=0 and frame_tick=0, overriding enable and any pending advance.
REQ-027 After reset with enable=1 and digit_mask[0]=0, anode SHALL select digit 0 (4'b1110 for DIGITS=4, ACTIVE_LOW=1).

Verification (DIGITS=4, DWELL=2, ACTIVE_LOW=1)
REQ-028 Reset, enable=1, mask=0 -> anode sequence 1110,1110,1101,1101,1011,1011,0111,0111,1110; frame_tick=1 only in the first cycle of the returning 1110.
REQ-029 mask=4'b0101 -> anode alternates 1101 (2 cycles) and 0111 (2 cycles); frame_tick pulses on each return to 1101.
REQ-030 mask=4'b1111 -> anode=1111, seg=7'h7F, dp_out=1, digit_idx constant, frame_tick never asserts.
REQ-031 values[11:8]=4'hA, dp[2]=1 -> while anode=1011, seg=7'h08 and dp_out=0; digit 0 with nibble 0 -> seg=7'h40.
REQ-032 enable dropped after 1 cycle on digit 1 for 5 cycles -> anode=1111 throughout, then 1101 for 1 more cycle before 1011.
REQ-033 reset asserted while idx=3 -> next cycle digit_idx=0, anode=1110, frame_tick=0, full 2-cycle dwell follows.
